path_rom_streamer: RTL and testbench

- Read-side sequencer for the per-core 512x10 path ROMs: it issues addresses to a ROM and consumes its data.
- The ROM has one-cycle read latency: it registers data on the clock edge that samples the address, and it cannot stall.
- On a start command, the block walks a contiguous, wrapping address window and delivers each word on a valid/ready stream, with last and done signalling.
- A 3-entry output FIFO absorbs in-flight ROM data, so backpressure never loses or duplicates a word and throughput stays at one word per cycle.

---
 rtl/path_rom_streamer.sv | 158 +++++++++++++++
 tb/tb_path_rom_streamer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_rom_streamer.sv
// path_rom_streamer
//   Read-side sequencer for a path ROM with one-cycle read latency. A start
//   command latches a base address and a length; the block then walks a
//   contiguous address window (wrapping at 2^ADDR_W) and delivers each ROM
//   word on a valid/ready stream. A 3-entry FIFO holds in-flight ROM data so
//   that backpressure never drops or duplicates a word, while still allowing
//   one word per cycle when the consumer is always ready.
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   iSTART     start request, sampled only while idle
//   iBASE      first ROM address of the walk
//   iLENGTH    number of words (clamped to 2^ADDR_W)
//   oADDRESS   registered ROM address
//   iROM_DATA  ROM word addressed on the previous edge
//   oDATA      stream data (head of FIFO, zero when not valid)
//   oVALID     stream valid (FIFO not empty)
//   iREADY     consumer ready
//   oLAST      current beat is the final word of the walk
//   oBUSY      a walk is in progress
//   oDONE      one-cycle pulse when a walk completes
module path_rom_streamer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iSTART,
    input  logic [ADDR_W-1:0] iBASE,
    input  logic [ADDR_W:0]   iLENGTH,
    output logic [ADDR_W-1:0] oADDRESS,
    input  logic [DATA_W-1:0] iROM_DATA,
    output logic [DATA_W-1:0] oDATA,
    output logic              oVALID,
    input  logic              iREADY,
    output logic              oLAST,
    output logic              oBUSY,
    output logic              oDONE
);

    localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   issue_left;
    logic [ADDR_W:0]   beats_left;
    logic              inflight;

    logic [DATA_W-1:0] fifo_mem [3];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [1:0]        fifo_count;

    logic [ADDR_W:0]   start_len;
    logic              start_acc;
    logic              fetch;
    logic              push;
    logic              pop;

    // Circular pointer step for the 3-entry FIFO.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Any length with the top bit set is >= 2^ADDR_W, so it clamps to a full sweep.
    assign start_len = iLENGTH[ADDR_W] ? FULL_LEN : iLENGTH;
    assign start_acc = (state == IDLE) && iSTART;

    // Occupancy counts the word still coming out of the ROM, so the FIFO can
    // never overflow even though the fetch decision ignores iREADY.
    assign fetch = (state == RUN) && (issue_left != '0)
                   && (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd3);
    assign push  = inflight;
    assign pop   = oVALID && iREADY;

    assign oADDRESS = rd_addr;
    assign oVALID   = (fifo_count != 2'd0);
    assign oDATA    = oVALID ? fifo_mem[rd_ptr] : '0;
    assign oLAST    = oVALID && (beats_left == ONE_LEN);
    assign oBUSY    = (state != IDLE);
    assign oDONE    = (state == FINISH);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (iSTART) begin
                    state_nxt = (start_len == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (pop && oLAST) begin
                    state_nxt = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            rd_addr    <= '0;
            issue_left <= '0;
            beats_left <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 2'd0;
        end else begin
            state    <= state_nxt;
            inflight <= fetch;

            // Issue side: address and remaining fetch count.
            if (start_acc) begin
                rd_addr    <= iBASE;
                issue_left <= start_len;
            end else if (fetch) begin
                rd_addr    <= rd_addr + ONE_ADDR;
                issue_left <= issue_left - ONE_LEN;
            end

            // Delivery side: beats remaining and FIFO bookkeeping.
            if (start_acc) begin
                beats_left <= start_len;
            end else if (pop) begin
                beats_left <= beats_left - ONE_LEN;
            end

            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage carries data only; validity comes from fifo_count.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= iROM_DATA;
        end
    end

endmodule

// File: tb/tb_path_rom_streamer.sv
// Testbench for path_rom_streamer: a ROM model returning data = address,
// a scoreboard queue filled at each start, and a negedge monitor that pops
// and compares every accepted beat.
module tb_path_rom_streamer;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 10;

    logic              CLK = 1'b0;
    logic              RST;
    logic              iSTART;
    logic [ADDR_W-1:0] iBASE;
    logic [ADDR_W:0]   iLENGTH;
    logic [ADDR_W-1:0] oADDRESS;
    logic [DATA_W-1:0] iROM_DATA;
    logic [DATA_W-1:0] oDATA;
    logic              oVALID;
    logic              iREADY;
    logic              oLAST;
    logic              oBUSY;
    logic              oDONE;

    path_rom_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .iSTART    (iSTART),
        .iBASE     (iBASE),
        .iLENGTH   (iLENGTH),
        .oADDRESS  (oADDRESS),
        .iROM_DATA (iROM_DATA),
        .oDATA     (oDATA),
        .oVALID    (oVALID),
        .iREADY    (iREADY),
        .oLAST     (oLAST),
        .oBUSY     (oBUSY),
        .oDONE     (oDONE)
    );

    always #5 CLK = ~CLK;

    // ROM with one-cycle latency, contents equal to the address.
    always @(posedge CLK) iROM_DATA <= DATA_W'(oADDRESS);

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int beat_cnt = 0;
    int vld_seen = 0;
    int first_vld_cyc = -1;
    int last_cyc = -1;
    int done_cyc = -1;
    int done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Monitor: compares accepted beats against the scoreboard and checks
    // that a stalled beat holds its data.
    initial begin
        beat_t             e;
        logic              prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic              prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", int'(oVALID), 1);
                    chk("stall_data", int'(oDATA), int'(prev_data));
                    chk("stall_last", int'(oLAST), int'(prev_last));
                end
                if (oVALID) begin
                    vld_seen++;
                    if (first_vld_cyc < 0) first_vld_cyc = cyc;
                end
                if (oVALID && iREADY) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0d, expected no beat", oDATA);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", int'(oDATA), int'(e.data));
                        chk("beat_last", int'(oLAST), int'(e.last));
                    end
                    beat_cnt++;
                    if (oLAST) last_cyc = cyc;
                end
                if (oDONE) begin
                    chk("busy_with_done", int'(oBUSY), 1);
                    done_cyc = cyc;
                    done_cnt++;
                end
                prev_stall = oVALID && !iREADY;
                prev_data  = oDATA;
                prev_last  = oLAST;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Issues a start and loads the expected beats; s = cycle index after the start edge.
    task automatic start_walk(input int base, input int len, output int s);
        int n;
        n = (len > 512) ? 512 : len;
        @(posedge CLK);
        #1;
        first_vld_cyc = -1;
        last_cyc      = -1;
        done_cyc      = -1;
        beat_cnt      = 0;
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.data = DATA_W'((base + i) % 512);
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
        iSTART  = 1'b1;
        iBASE   = ADDR_W'(base);
        iLENGTH = (ADDR_W + 1)'(len);
        @(posedge CLK);
        #1;
        s = cyc;
        iSTART = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cyc < 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no oDONE within %0d cycles, expected a pulse", budget);
        end else begin
            while (cyc < done_cyc + 1) @(negedge CLK);
            chk("busy_after_done", int'(oBUSY), 0);
            chk("done_single_pulse", int'(oDONE), 0);
        end
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (beat_cnt < target && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("beat_wait", (beat_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"},  int'(oADDRESS), 0);
        chk({tag, "_data"},  int'(oDATA), 0);
        chk({tag, "_valid"}, int'(oVALID), 0);
        chk({tag, "_last"},  int'(oLAST), 0);
        chk({tag, "_busy"},  int'(oBUSY), 0);
        chk({tag, "_done"},  int'(oDONE), 0);
    endtask

    initial begin
        int s;
        int n;
        int vs;
        int dc;

        RST     = 1'b1;
        iSTART  = 1'b0;
        iBASE   = '0;
        iLENGTH = '0;
        iREADY  = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Basic 4-word walk.
        start_walk(0, 4, s);
        wait_done(50);
        chk("t1_first_valid", first_vld_cyc, s + 2);
        chk("t1_last_cycle", last_cyc, s + 5);
        chk("t1_done_cycle", done_cyc, s + 6);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Address wrap 510, 511, 0, 1.
        start_walk(510, 4, s);
        @(negedge CLK);
        chk("t2_addr_base", int'(oADDRESS), 510);
        @(negedge CLK);
        chk("t2_addr_511", int'(oADDRESS), 511);
        @(negedge CLK);
        chk("t2_addr_wrap", int'(oADDRESS), 0);
        wait_done(50);
        chk("t2_done_cycle", done_cyc, s + 6);
        chk("t2_queue_empty", exp_q.size(), 0);

        // Backpressure: stall 6 cycles at beat 5, then toggle ready.
        start_walk(0, 20, s);
        wait_beats(5);
        iREADY = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        chk("t3_fetch_frozen_addr", int'(oADDRESS), 8);
        chk("t3_stalled_head", int'(oDATA), 5);
        n = 0;
        while (done_cyc < 0 && n < 200) begin
            iREADY = ~iREADY;
            @(posedge CLK);
            #1;
            n++;
        end
        iREADY = 1'b1;
        chk("t3_done_seen", (done_cyc >= 0) ? 1 : 0, 1);
        chk("t3_beat_count", beat_cnt, 20);
        chk("t3_queue_empty", exp_q.size(), 0);
        repeat (2) @(posedge CLK);

        // Zero length: immediate done, no valid.
        vs = vld_seen;
        dc = done_cnt;
        start_walk(0, 0, s);
        repeat (3) @(negedge CLK);
        chk("t4_done_cycle", done_cyc, s);
        chk("t4_done_count", done_cnt - dc, 1);
        chk("t4_no_valid", vld_seen - vs, 0);

        // Length 600 clamps to a full 512-word sweep.
        start_walk(0, 600, s);
        wait_done(700);
        chk("t5_beat_count", beat_cnt, 512);
        chk("t5_last_cycle", last_cyc, s + 513);
        chk("t5_done_cycle", done_cyc, s + 514);
        chk("t5_queue_empty", exp_q.size(), 0);

        // Full 512-word walk at full throughput.
        start_walk(0, 512, s);
        wait_done(700);
        chk("t6_first_valid", first_vld_cyc, s + 2);
        chk("t6_last_cycle", last_cyc, s + 513);
        chk("t6_done_cycle", done_cyc, s + 514);
        chk("t6_queue_empty", exp_q.size(), 0);

        // Start while busy is ignored.
        dc = done_cnt;
        start_walk(40, 10, s);
        repeat (3) @(posedge CLK);
        #1;
        iSTART  = 1'b1;
        iBASE   = ADDR_W'(300);
        iLENGTH = (ADDR_W + 1)'(5);
        @(posedge CLK);
        #1;
        iSTART = 1'b0;
        wait_done(50);
        chk("t7_last_cycle", last_cyc, s + 11);
        chk("t7_done_cycle", done_cyc, s + 12);
        repeat (5) @(negedge CLK);
        chk("t7_done_count", done_cnt - dc, 1);
        chk("t7_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a walk, then a fresh walk.
        start_walk(0, 20, s);
        wait_beats(7);
        RST = 1'b1;
        #1;
        check_all_zero("t8_midreset");
        exp_q.delete();
        dc = done_cnt;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t8_no_done_after_reset", done_cnt - dc, 0);
        chk("t8_idle_valid", int'(oVALID), 0);
        start_walk(100, 3, s);
        wait_done(50);
        chk("t8_beat_count", beat_cnt, 3);
        chk("t8_last_cycle", last_cyc, s + 4);
        chk("t8_done_cycle", done_cyc, s + 5);
        chk("t8_queue_empty", exp_q.size(), 0);

        repeat (2) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
